// File: rtl/imm_field_encoder.sv
// imm_field_encoder: packs a 64-bit immediate into the 26-bit instruction
// immediate field for the I/D/B/CB formats. It flags values the selected
// format cannot represent and keeps a saturating count of flagged results.
// Two-stage valid/ready pipeline: S1 holds the raw value, S2 holds the result.
`timescale 1ns/1ps
module imm_field_encoder #(
    parameter int ERRW = 8
) (
    input  logic            CLK,
    input  logic            Reset,
    input  logic            InValid,
    output logic            InReady,
    input  logic [63:0]     BusImm,
    input  logic [1:0]      Ctrl,
    output logic            OutValid,
    input  logic            OutReady,
    output logic [25:0]     Imm26,
    output logic [1:0]      CtrlOut,
    output logic            Err,
    output logic [ERRW-1:0] ErrCount,
    input  logic            ClrErr
);

    // Handshake rule: a transfer happens on a rising edge where valid && ready.
    // The producer holds data stable while valid && !ready. InReady depends
    // combinationally on OutReady, so a full pipeline streams without bubbles.

    localparam logic [1:0] FMT_I  = 2'b00;
    localparam logic [1:0] FMT_D  = 2'b01;
    localparam logic [1:0] FMT_B  = 2'b10;
    localparam logic [1:0] FMT_CB = 2'b11;

    logic            s1_valid_q, s1_valid_d;
    logic [63:0]     s1_imm_q, s1_imm_d;
    logic [1:0]      s1_ctrl_q, s1_ctrl_d;
    logic            s2_valid_q, s2_valid_d;
    logic [25:0]     s2_imm26_q, s2_imm26_d;
    logic [1:0]      s2_ctrl_q, s2_ctrl_d;
    logic            s2_err_q, s2_err_d;
    logic [ERRW-1:0] err_cnt_q, err_cnt_d;

    logic            s2_load;
    logic            s1_load;
    logic            out_err_hs;
    logic [25:0]     enc_imm26;
    logic            enc_err;

    assign s2_load    = !s2_valid_q || OutReady;
    assign s1_load    = !s1_valid_q || s2_load;
    assign out_err_hs = s2_valid_q && OutReady && s2_err_q;

    assign InReady  = s1_load;
    assign OutValid = s2_valid_q;
    assign Imm26    = s2_imm26_q;
    assign CtrlOut  = s2_ctrl_q;
    assign Err      = s2_err_q;
    assign ErrCount = err_cnt_q;

    // Encode the S1 value: place the field bits, then check that the upper
    // bits are a pure sign/zero extension and that branch offsets are word aligned.
    always_comb begin
        enc_imm26 = '0;
        enc_err   = 1'b0;
        case (s1_ctrl_q)
            FMT_I: begin
                enc_err          = |s1_imm_q[63:12];
                enc_imm26[21:10] = s1_imm_q[11:0];
            end
            FMT_D: begin
                enc_err          = !((&s1_imm_q[63:8]) || !(|s1_imm_q[63:8]));
                enc_imm26[20:12] = s1_imm_q[8:0];
            end
            FMT_B: begin
                enc_err          = (|s1_imm_q[1:0]) ||
                                   !((&s1_imm_q[63:27]) || !(|s1_imm_q[63:27]));
                enc_imm26[25:0]  = s1_imm_q[27:2];
            end
            FMT_CB: begin
                enc_err          = (|s1_imm_q[1:0]) ||
                                   !((&s1_imm_q[63:20]) || !(|s1_imm_q[63:20]));
                enc_imm26[23:5]  = s1_imm_q[20:2];
            end
        endcase
        if (enc_err) begin
            enc_imm26 = '0;
        end
    end

    // Next-state for both stages and the error counter; stages hold when stalled.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_imm_d   = s1_imm_q;
        s1_ctrl_d  = s1_ctrl_q;
        s2_valid_d = s2_valid_q;
        s2_imm26_d = s2_imm26_q;
        s2_ctrl_d  = s2_ctrl_q;
        s2_err_d   = s2_err_q;
        err_cnt_d  = err_cnt_q;

        if (s1_load) begin
            s1_valid_d = InValid;
            if (InValid) begin
                s1_imm_d  = BusImm;
                s1_ctrl_d = Ctrl;
            end
        end

        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_imm26_d = enc_imm26;
                s2_ctrl_d  = s1_ctrl_q;
                s2_err_d   = enc_err;
            end
        end

        // Clear takes priority over a coincident erroneous handoff.
        if (ClrErr) begin
            err_cnt_d = '0;
        end else if (out_err_hs && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERRW'(1);
        end
    end

    // State registers; reset drops anything in flight.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            s1_valid_q <= 1'b0;
            s1_imm_q   <= '0;
            s1_ctrl_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_imm26_q <= '0;
            s2_ctrl_q  <= '0;
            s2_err_q   <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_imm_q   <= s1_imm_d;
            s1_ctrl_q  <= s1_ctrl_d;
            s2_valid_q <= s2_valid_d;
            s2_imm26_q <= s2_imm26_d;
            s2_ctrl_q  <= s2_ctrl_d;
            s2_err_q   <= s2_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_imm_field_encoder.sv
// Bench for imm_field_encoder: scenario tasks plus a scoreboard that predicts
// each result from the format's numeric range rules and a SignExtender model.
`timescale 1ns/1ps
module tb_imm_field_encoder;

    logic        CLK = 1'b0;
    logic        Reset = 1'b0;
    logic        InValid = 1'b0;
    logic        InReady;
    logic [63:0] BusImm = '0;
    logic [1:0]  Ctrl = '0;
    logic        OutValid;
    logic        OutReady = 1'b1;
    logic [25:0] Imm26;
    logic [1:0]  CtrlOut;
    logic        Err;
    logic [7:0]  ErrCount;
    logic        ClrErr = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int model_cnt = 0;
    int out_cnt = 0;
    bit lat_chk = 1'b0;

    logic [28:0] exp_q[$];   // {ctrl, err, imm26}
    logic [63:0] imm_q[$];
    int          lat_q[$];

    imm_field_encoder #(.ERRW(8)) dut (
        .CLK(CLK), .Reset(Reset), .InValid(InValid), .InReady(InReady),
        .BusImm(BusImm), .Ctrl(Ctrl), .OutValid(OutValid), .OutReady(OutReady),
        .Imm26(Imm26), .CtrlOut(CtrlOut), .Err(Err), .ErrCount(ErrCount),
        .ClrErr(ClrErr)
    );

    // clock / cycle counter
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // reference: representable ranges of each format, plain arithmetic
    function automatic logic [28:0] ref_encode(input logic [1:0] c, input logic [63:0] v);
        longint s;
        logic   e;
        logic [25:0] f;
        s = $signed(v);
        case (c)
            2'd0: begin e = (v > 64'd4095); f = 26'((v % 64'd4096) << 10); end
            2'd1: begin e = (s < -256) || (s > 255); f = 26'((v % 64'd512) << 12); end
            2'd2: begin
                e = (v % 64'd4 != 0) || (s < -(longint'(1) <<< 27)) || (s > (longint'(1) <<< 27) - 1);
                f = 26'(v >> 2);
            end
            default: begin
                e = (v % 64'd4 != 0) || (s < -(longint'(1) <<< 20)) || (s > (longint'(1) <<< 20) - 1);
                f = 26'(((v >> 2) % 64'd524288) << 5);
            end
        endcase
        if (e) f = '0;
        return {c, e, f};
    endfunction

    // SignExtender model used for the round-trip check
    function automatic logic [63:0] sign_ext(input logic [25:0] f, input logic [1:0] c);
        longint x;
        case (c)
            2'd0: x = longint'((f >> 10) % 26'd4096);
            2'd1: begin x = longint'((f >> 12) % 26'd512); if (x >= 256) x = x - 512; end
            2'd2: begin x = longint'(f); if (x >= (longint'(1) <<< 25)) x = x - (longint'(1) <<< 26); x = x * 4; end
            default: begin
                x = longint'((f >> 5) % 26'd524288);
                if (x >= (longint'(1) <<< 18)) x = x - (longint'(1) <<< 19);
                x = x * 4;
            end
        endcase
        return 64'(x);
    endfunction

    function automatic logic [63:0] rand_val(input logic [1:0] c);
        longint lo, hi, st, x;
        int m;
        case (c)
            2'd0: begin lo = 0; hi = 4095; st = 1; end
            2'd1: begin lo = -256; hi = 255; st = 1; end
            2'd2: begin lo = -(longint'(1) <<< 27); hi = (longint'(1) <<< 27) - 4; st = 4; end
            default: begin lo = -(longint'(1) <<< 20); hi = (longint'(1) <<< 20) - 4; st = 4; end
        endcase
        m = int'($urandom_range(0, 9));
        x = lo + st * longint'($urandom_range(0, 32'((hi - lo) / st)));
        if (m >= 5 && m < 7) begin
            case ($urandom_range(0, 3))
                0: x = lo;
                1: x = hi;
                2: x = lo - st;
                default: x = hi + st;
            endcase
        end else if (m >= 7 && m < 9) begin
            x = x + longint'($urandom_range(1, 3));
        end else if (m == 9) begin
            x = longint'({$urandom, $urandom});
        end
        return 64'(x);
    endfunction

    // scoreboard: sampled between edges, after all bench drives have settled
    always @(negedge CLK) begin
        logic [28:0] e;
        logic [63:0] v;
        int          l;
        #2;
        if (!Reset) begin
            checks++;
            if (ErrCount !== 8'(model_cnt)) begin
                errors++;
                $display("FAIL errcount: got %0d want %0d", ErrCount, model_cnt);
            end
            if (OutValid && OutReady) begin
                out_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL stray_output: got imm26=%h with nothing expected", Imm26);
                end else begin
                    e = exp_q.pop_front();
                    v = imm_q.pop_front();
                    l = lat_q.pop_front();
                    if ({CtrlOut, Err, Imm26} !== e) begin
                        errors++;
                        $display("FAIL result: busimm=%h got ctrl=%0d err=%0d imm26=%h want ctrl=%0d err=%0d imm26=%h",
                                 v, CtrlOut, Err, Imm26, e[28:27], e[26], e[25:0]);
                    end
                    if (!e[26]) begin
                        checks++;
                        if (sign_ext(Imm26, CtrlOut) !== v) begin
                            errors++;
                            $display("FAIL roundtrip: got %h want %h", sign_ext(Imm26, CtrlOut), v);
                        end
                    end
                    if (lat_chk) begin
                        checks++;
                        if (cyc - l != 2) begin
                            errors++;
                            $display("FAIL latency: got %0d want 2", cyc - l);
                        end
                    end
                    if (!ClrErr && e[26] && model_cnt < 255) model_cnt++;
                end
            end
            if (ClrErr) model_cnt = 0;
            if (InValid && InReady) begin
                exp_q.push_back(ref_encode(Ctrl, BusImm));
                imm_q.push_back(BusImm);
                lat_q.push_back(cyc);
            end
        end
    end

    // driver: present one item and hold it until accepted
    task automatic send(input logic [1:0] c, input logic [63:0] v);
        InValid = 1'b1;
        Ctrl = c;
        BusImm = v;
        for (int k = 0; k < 300; k++) begin
            @(negedge CLK);
            if (InReady) begin
                @(posedge CLK); #1;
                return;
            end
            @(posedge CLK); #1;
        end
        errors++;
        $display("FAIL send_timeout: InReady stuck at 0 want 1");
    endtask

    task automatic drain();
        InValid = 1'b0;
        for (int k = 0; k < 300 && exp_q.size() != 0; k++) @(posedge CLK);
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results outstanding want 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        #2 Reset = 1'b1;
        for (int r = 0; r < 2; r++) begin
            #1;
            checks += 6;
            if (OutValid !== 1'b0) begin errors++; $display("FAIL rst_outvalid: got %b want 0", OutValid); end
            if (Imm26 !== 26'd0)   begin errors++; $display("FAIL rst_imm26: got %h want 0", Imm26); end
            if (CtrlOut !== 2'd0)  begin errors++; $display("FAIL rst_ctrlout: got %0d want 0", CtrlOut); end
            if (Err !== 1'b0)      begin errors++; $display("FAIL rst_err: got %b want 0", Err); end
            if (ErrCount !== 8'd0) begin errors++; $display("FAIL rst_errcount: got %0d want 0", ErrCount); end
            if (InReady !== 1'b1)  begin errors++; $display("FAIL rst_inready: got %b want 1", InReady); end
            repeat (2) @(posedge CLK);
        end
        #1 Reset = 1'b0;
        @(posedge CLK); #1;
    endtask

    // fixed four-item table, one per cycle, outputs checked inline at fixed offsets
    task automatic run_table(input string name, input logic [1:0] tc[4], input logic [63:0] tv[4],
                             input logic [25:0] te[4], input logic terr);
        OutReady = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k < 4) begin InValid = 1'b1; Ctrl = tc[k]; BusImm = tv[k]; end
            else InValid = 1'b0;
            @(negedge CLK);
            if (k < 4) begin
                checks++;
                if (InReady !== 1'b1) begin errors++; $display("FAIL %s_inready[%0d]: got %b want 1", name, k, InReady); end
            end
            if (k >= 2) begin
                checks += 4;
                if (OutValid !== 1'b1) begin errors++; $display("FAIL %s_outvalid[%0d]: got %b want 1", name, k-2, OutValid); end
                if (Imm26 !== te[k-2]) begin errors++; $display("FAIL %s_imm26[%0d]: got %h want %h", name, k-2, Imm26, te[k-2]); end
                if (Err !== terr)      begin errors++; $display("FAIL %s_err[%0d]: got %b want %b", name, k-2, Err, terr); end
                if (CtrlOut !== tc[k-2]) begin errors++; $display("FAIL %s_ctrl[%0d]: got %0d want %0d", name, k-2, CtrlOut, tc[k-2]); end
            end
            @(posedge CLK); #1;
        end
        drain();
    endtask

    task automatic test_streaming();
        logic [1:0]  tc[4];
        logic [63:0] tv[4];
        logic [25:0] te[4];
        tc = '{2'd0, 2'd1, 2'd2, 2'd3};
        tv = '{64'h3, 64'hFFFF_FFFF_FFFF_FF03, 64'h0000_0000_00FF_F354, 64'hFFFF_FFFF_FFFF_F9A8};
        te = '{26'h000C00, 26'h103000, 26'h3FFCD5, 26'hFFCD40};
        lat_chk = 1'b1;
        run_table("stream", tc, tv, te, 1'b0);
        lat_chk = 1'b0;
    endtask

    task automatic test_errors();
        logic [1:0]  tc[4];
        logic [63:0] tv[4];
        logic [25:0] te[4];
        tc = '{2'd0, 2'd1, 2'd2, 2'd3};
        tv = '{64'h1000, 64'h100, 64'h5, 64'h0000_0000_0010_0000};
        te = '{26'd0, 26'd0, 26'd0, 26'd0};
        run_table("errors", tc, tv, te, 1'b1);
        checks++;
        if (ErrCount !== 8'd4) begin errors++; $display("FAIL errors_count: got %0d want 4", ErrCount); end
    endtask

    task automatic test_backpressure();
        logic [63:0] vals[12];
        logic [25:0] snap_imm;
        logic [1:0]  snap_ctrl;
        logic        snap_err;
        int i, base;
        for (int k = 0; k < 12; k++) vals[k] = rand_val(2'(k));
        i = 0;
        base = out_cnt;
        OutReady = 1'b0;
        snap_imm = '0; snap_ctrl = '0; snap_err = 1'b0;
        for (int k = 0; k < 5; k++) begin
            InValid = 1'b1; Ctrl = 2'(i); BusImm = vals[i];
            @(negedge CLK);
            checks++;
            if (InReady !== (k < 2)) begin errors++; $display("FAIL bp_inready[%0d]: got %b want %b", k, InReady, (k < 2)); end
            if (k == 2) begin snap_imm = Imm26; snap_ctrl = CtrlOut; snap_err = Err; end
            if (k > 2) begin
                checks++;
                if (OutValid !== 1'b1 || {snap_ctrl, snap_err, snap_imm} !== {CtrlOut, Err, Imm26}) begin
                    errors++;
                    $display("FAIL bp_hold[%0d]: got v=%b %0d %b %h want v=1 %0d %b %h",
                             k, OutValid, CtrlOut, Err, Imm26, snap_ctrl, snap_err, snap_imm);
                end
            end
            if (InReady) i++;
            @(posedge CLK); #1;
        end
        OutReady = 1'b1;
        while (i < 12) begin
            send(2'(i), vals[i]);
            i++;
        end
        drain();
        checks++;
        if (out_cnt - base != 12) begin errors++; $display("FAIL bp_count: got %0d want 12", out_cnt - base); end
    endtask

    task automatic test_random();
        bit done;
        done = 1'b0;
        fork
            begin
                for (int n = 0; n < 300; n++) begin
                    logic [1:0] c;
                    c = 2'($urandom_range(0, 3));
                    send(c, rand_val(c));
                    if ($urandom_range(0, 3) == 0) begin
                        InValid = 1'b0;
                        repeat ($urandom_range(1, 3)) @(posedge CLK);
                        #1;
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge CLK); #1;
                    OutReady = ($urandom_range(0, 2) != 0);
                end
            end
        join
        OutReady = 1'b1;
        drain();
    endtask

    task automatic test_reset_midstream();
        logic [63:0] v;
        int k;
        OutReady = 1'b0;
        // a few erroneous items so the counter is nonzero before reset
        send(2'd2, 64'h1);
        OutReady = 1'b1;
        send(2'd2, 64'h2);
        OutReady = 1'b0;
        InValid = 1'b1; Ctrl = 2'd0; BusImm = 64'h7;
        for (k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (!InReady) break;
            @(posedge CLK); #1;
        end
        checks++;
        if (k == 20) begin errors++; $display("FAIL mid_fill: InReady got 1 want 0"); end
        @(posedge CLK);
        #3 Reset = 1'b1;
        #1;
        checks += 4;
        if (OutValid !== 1'b0) begin errors++; $display("FAIL mid_outvalid: got %b want 0", OutValid); end
        if (Imm26 !== 26'd0)   begin errors++; $display("FAIL mid_imm26: got %h want 0", Imm26); end
        if (ErrCount !== 8'd0) begin errors++; $display("FAIL mid_errcount: got %0d want 0", ErrCount); end
        if (Err !== 1'b0)      begin errors++; $display("FAIL mid_err: got %b want 0", Err); end
        exp_q.delete(); imm_q.delete(); lat_q.delete();
        model_cnt = 0;
        InValid = 1'b0;
        OutReady = 1'b1;
        @(posedge CLK); #1 Reset = 1'b0;
        lat_chk = 1'b1;
        v = 64'hFFFF_FFFF_FFFF_FF80;
        InValid = 1'b1; Ctrl = 2'd1; BusImm = v;
        @(negedge CLK);
        checks++;
        if (InReady !== 1'b1) begin errors++; $display("FAIL mid_accept: got %b want 1", InReady); end
        @(posedge CLK); #1 InValid = 1'b0;
        @(negedge CLK);
        checks++;
        if (OutValid !== 1'b0) begin errors++; $display("FAIL mid_early: got %b want 0", OutValid); end
        @(negedge CLK);
        checks++;
        if (OutValid !== 1'b1 || Imm26 !== 26'h180000) begin
            errors++;
            $display("FAIL mid_first: got v=%b imm26=%h want v=1 imm26=180000", OutValid, Imm26);
        end
        drain();
        lat_chk = 1'b0;
    endtask

    task automatic test_errcount_sat();
        int k;
        OutReady = 1'b1;
        for (int n = 0; n < 256; n++) send(2'd3, 64'(($urandom_range(0, 1000) << 2) | 1));
        drain();
        checks++;
        if (ErrCount !== 8'd255) begin errors++; $display("FAIL sat_count: got %0d want 255", ErrCount); end
        send(2'd2, 64'h3);
        InValid = 1'b0;
        for (k = 0; k < 10; k++) begin
            @(negedge CLK);
            if (OutValid) break;
        end
        checks++;
        if (k == 10 || Err !== 1'b1) begin errors++; $display("FAIL clr_setup: got v=%b err=%b want 1 1", OutValid, Err); end
        #1 ClrErr = 1'b1;
        @(posedge CLK); #1 ClrErr = 1'b0;
        checks++;
        if (ErrCount !== 8'd0) begin errors++; $display("FAIL clr_wins: got %0d want 0", ErrCount); end
        drain();
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_errors();
        test_backpressure();
        test_random();
        test_reset_midstream();
        test_errcount_sat();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // global time bound
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

endmodule

// File: doc/imm_field_encoder.md
Name: imm_field_encoder

Overview:
- Inverse of the SignExtender.
- Accepts a 64-bit immediate value (BusImm) plus a format selector (Ctrl) and produces the 26-bit instruction immediate field (Imm26) that the SignExtender decodes back to the same BusImm.
- Range- and alignment-checks each value, and counts errors.
- Sits between the program loader/assembler front end and instruction memory. Two-stage pipeline with valid/ready handshakes on both sides.

Parameters:
- ERRW, 8, width of the saturating error counter.

Ports:
- CLK  input  1  clock; all state updates on rising edge
- Reset  input  1  asynchronous, active-high reset
- InValid  input  1  upstream presents BusImm/Ctrl
- InReady  output  1  block accepts input this cycle
- BusImm  input  64  immediate value to encode
- Ctrl  input  2  format: 00 I, 01 D, 10 B, 11 CB
- OutValid  output  1  Imm26/Err/CtrlOut valid
- OutReady  input  1  downstream accepts output
- Imm26  output  26  encoded field; unused bit positions 0
- CtrlOut  output  2  Ctrl echoed with the result
- Err  output  1  value not representable in the selected format
- ErrCount  output  ERRW  saturating count of erroneous results handed off
- ClrErr  input  1  synchronous clear of ErrCount

Behaviour:
- Reset (async, any cycle, including mid-transfer):
  - Both stage valids are 0, so OutValid=0.
  - Imm26=0, CtrlOut=0, Err=0, ErrCount=0.
  - Any in-flight data is discarded.
- Handshakes:
  - A transfer occurs on a rising edge where valid&&ready.
  - Upstream must hold BusImm/Ctrl stable while InValid&&!InReady.
  - Outputs are held stable while OutValid&&!OutReady.
- Stage 1 (S1) registers BusImm and Ctrl.
- Stage 2 (S2) registers the encoded result. S2 drives the outputs directly.
- Latency: 2 cycles from input accept to OutValid with no stall. Throughput 1 per cycle.
- Advance and ready rules:
  - S2 loads when !OutValid || OutReady.
  - S1 loads when !S1Valid || S2 loads.
  - InReady = !S1Valid || S2 loads. This is combinational from OutReady; there are no bubbles under continuous flow.
- Encoding (computed combinationally from S1, registered into S2):
  - I (00): Imm26[21:10]=BusImm[11:0]. Error if BusImm[63:12]!=0 (unsigned, 0..4095).
  - D (01): Imm26[20:12]=BusImm[8:0]. Error unless BusImm[63:8] are all equal (signed, -256..255).
  - B (10): Imm26[25:0]=BusImm[27:2]. Error if BusImm[1:0]!=0, or unless BusImm[63:27] are all equal.
  - CB (11): Imm26[23:5]=BusImm[20:2]. Error if BusImm[1:0]!=0, or unless BusImm[63:20] are all equal.
- On error: Imm26=0, Err=1, CtrlOut still echoes Ctrl. Otherwise Err=0.
- Round trip: for every non-error result, SignExtender(Imm26, Ctrl) == BusImm.
- ErrCount:
  - Increments by 1 on each output handshake (OutValid&&OutReady) with Err=1.
  - Saturates at 2^ERRW-1.
  - ClrErr sets it to 0 on the next edge. If ClrErr coincides with an erroneous handshake, clear wins (result 0).
- Stall: if OutReady=0 for N cycles with both stages full, the S2 result is unchanged, S1 holds, and InReady=0.

Test Plan:
- Streaming, OutReady=1, four back-to-back inputs; each result appears 2 cycles after acceptance, one per cycle, and the encoded values must round-trip through SignExtender:
  - Ctrl=00, BusImm=0x3 -> Imm26=0x000C00, Err=0.
  - Ctrl=01, BusImm=0xFFFFFFFFFFFFFF03 -> Imm26=0x103000, Err=0.
  - Ctrl=10, BusImm=0x0000000000FFF354 -> Imm26=0x3FFCD5, Err=0.
  - Ctrl=11, BusImm=0xFFFFFFFFFFFFF9A8 -> Imm26=0xFFCD40, Err=0.
- Errors, sent in order: (00, 0x1000), (01, 0x100), (10, 0x5), (11, 0x0000000000100000) -> each Imm26=0, Err=1; ErrCount ends at 4.
- Backpressure: hold OutReady=0 for 5 cycles while streaming -> InReady=0 from the 3rd cycle on, outputs stable, no loss or duplication after release; output order equals input order.
- ErrCount: drive 256 erroneous transfers -> ErrCount=255 (saturated). Then assert ClrErr on the same edge as another erroneous handshake -> ErrCount=0.
- Reset mid-stream: assert Reset asynchronously with both stages full -> OutValid=0, Imm26=0, ErrCount=0 immediately; after release, the first new input emerges after 2 cycles.
